// File: rtl/pwm_pkg.sv
// Shared PWM definitions: datapath widths and types used by the register file,
// the timebase counter and the PWM compare stage.
package pwm_pkg;

  localparam int CNT_W = 16;
  localparam int PSC_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [PSC_W-1:0] psc_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/prescaler_tick.sv
// Enable-gated clock divider: emits a one-cycle tick every prescale+1 enabled cycles.
module prescaler_tick #(
  parameter int PSC_W = pwm_pkg::PSC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             count_reset,
  input  logic [PSC_W-1:0] prescale,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt_q;
  logic [PSC_W-1:0] psc_cnt_d;

  // The >= compare makes a lowered prescale fire on the next enabled edge.
  assign tick = en && !count_reset && (psc_cnt_q >= prescale);

  always_comb begin
    psc_cnt_d = psc_cnt_q;
    if (count_reset) begin
      psc_cnt_d = '0;
    end else if (tick) begin
      psc_cnt_d = '0;
    end else if (en) begin
      psc_cnt_d = psc_cnt_q + PSC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc_cnt_q <= '0;
    end else begin
      psc_cnt_q <= psc_cnt_d;
    end
  end

endmodule

// File: rtl/counter.sv
// Programmable up/down timebase for the PWM generator; counts between 0 and period
// on each prescaler tick and flags every wrap with a registered one-cycle pulse.
module counter #(
  parameter int CNT_W = pwm_pkg::CNT_W,
  parameter int PSC_W = pwm_pkg::PSC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             count_reset,
  input  logic             upnotdown,
  input  logic [CNT_W-1:0] period,
  input  logic [PSC_W-1:0] prescale,
  output logic [CNT_W-1:0] counter_val,
  output logic             wrap
);

  import pwm_pkg::*;

  logic             tick;
  dir_e             dir;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;

  assign dir = dir_e'(upnotdown);

  prescaler_tick #(
    .PSC_W(PSC_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .count_reset(count_reset),
    .prescale   (prescale),
    .tick       (tick)
  );

  // Up mode uses >= so a period lowered below the count wraps instead of overflowing;
  // down mode simply keeps decrementing until it reaches 0.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (count_reset) begin
      cnt_d = '0;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        if (cnt_q >= period) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d  = period;
          wrap_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign counter_val = cnt_q;
  assign wrap        = wrap_q;

endmodule

// File: tb/tb_counter.sv
// Directed bench for the PWM timebase counter: hand-computed value/wrap sequences
// for up, down, prescale, enable, clear, period and direction changes, and async reset.
module tb_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        count_reset;
  logic        upnotdown;
  logic [15:0] period;
  logic [7:0]  prescale;
  logic [15:0] counter_val;
  logic        wrap;

  int checks   = 0;
  int failures = 0;
  int exp_cnt[$];
  int exp_wrap[$];

  counter dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .count_reset(count_reset),
    .upnotdown  (upnotdown),
    .period     (period),
    .prescale   (prescale),
    .counter_val(counter_val),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int ec, input int ew);
    $display("[%0t] %s counter_val=%0h wrap=%0b", $time, tag, counter_val, wrap);
    check({tag, ".cnt"}, 32'(counter_val), 32'(ec));
    check({tag, ".wrap"}, 32'(wrap), 32'(ew));
  endtask

  // Advance one edge per queued entry and compare against the queued values.
  task automatic run_seq(input string tag);
    for (int i = 0; i < exp_cnt.size(); i++) begin
      step();
      check_state($sformatf("%s[%0d]", tag, i), exp_cnt[i], exp_wrap[i]);
    end
  endtask

  task automatic clear_step(input string tag);
    count_reset = 1'b1;
    step();
    check_state(tag, 0, 0);
    count_reset = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    count_reset = 1'b0;
    upnotdown   = 1'b1;
    period      = 16'd0;
    prescale    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0);
    rst = 1'b0;

    // Up, period 3, every edge
    period = 16'd3;
    en     = 1'b1;
    exp_cnt  = {1, 2, 3, 0, 1, 2, 3, 0};
    exp_wrap = {0, 0, 0, 1, 0, 0, 0, 1};
    run_seq("up_p3");

    // Down, period 2, prescale 1
    upnotdown = 1'b0;
    period    = 16'd2;
    prescale  = 8'd1;
    clear_step("clr_down");
    exp_cnt  = {0, 2, 2, 1, 1, 0, 0, 2, 2};
    exp_wrap = {0, 1, 0, 0, 0, 0, 0, 1, 0};
    run_seq("down_p2");

    // Prescale 4 with an en gap mid-interval
    upnotdown = 1'b1;
    period    = 16'd10;
    prescale  = 8'd4;
    clear_step("clr_psc");
    exp_cnt  = {0, 0, 0};
    exp_wrap = {0, 0, 0};
    run_seq("psc_a");
    en = 1'b0;
    run_seq("psc_off");
    en = 1'b1;
    exp_cnt  = {0, 1, 1, 1, 1, 1, 2};
    exp_wrap = {0, 0, 0, 0, 0, 0, 0};
    run_seq("psc_b");

    // Clear at 7 with en high, then the next tick prescale+1 edges later
    prescale = 8'd0;
    exp_cnt  = {3, 4, 5, 6, 7};
    exp_wrap = {0, 0, 0, 0, 0};
    run_seq("to7");
    prescale = 8'd2;
    clear_step("clr_at7");
    exp_cnt  = {0, 0, 1};
    exp_wrap = {0, 0, 0};
    run_seq("after_clr");

    // Clear while disabled
    en = 1'b0;
    clear_step("clr_en0");
    en       = 1'b1;
    prescale = 8'd0;
    exp_cnt  = {1};
    exp_wrap = {0};
    run_seq("resume");

    // Period lowered below the current count in up mode
    period   = 16'd10;
    exp_cnt  = {2, 3, 4, 5, 6, 7, 8};
    exp_wrap = {0, 0, 0, 0, 0, 0, 0};
    run_seq("to8");
    period   = 16'd4;
    exp_cnt  = {0, 1};
    exp_wrap = {1, 0};
    run_seq("lower_per");

    // Period 0 wraps every tick, both directions
    period   = 16'd0;
    exp_cnt  = {0, 0, 0};
    exp_wrap = {1, 1, 1};
    run_seq("p0_up");
    upnotdown = 1'b0;
    exp_cnt  = {0, 0};
    exp_wrap = {1, 1};
    run_seq("p0_down");

    // Direction flip at 5
    upnotdown = 1'b1;
    period    = 16'd10;
    exp_cnt  = {1, 2, 3, 4, 5};
    exp_wrap = {0, 0, 0, 0, 0};
    run_seq("to5");
    upnotdown = 1'b0;
    exp_cnt  = {4, 3};
    exp_wrap = {0, 0};
    run_seq("flip");

    // Down with count above a lowered period keeps decrementing
    period   = 16'd1;
    exp_cnt  = {2, 1, 0, 1, 0};
    exp_wrap = {0, 0, 0, 1, 0};
    run_seq("down_above");

    // Async reset mid-count at 0x1234
    upnotdown = 1'b1;
    period    = 16'hFFFF;
    clear_step("clr_big");
    repeat (16'h1234) @(posedge clk);
    #1;
    check_state("at_1234", 16'h1234, 0);
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 0, 0);
    step();
    check_state("rst_hold", 0, 0);
    rst = 1'b0;
    exp_cnt  = {1, 2};
    exp_wrap = {0, 0};
    run_seq("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
